// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: decode-to-execute pipeline latch with operand forwarding
// and load-use hazard detection.
//
// Ports:
//   clk, clear        clock; asynchronous active-low reset
//   id_*              decode-slot instruction fields and register-file read data
//   {ex,mem,wb}_fw_*  destination, write-enable and result of downstream stages
//   flush, ex_hold    kill the decode slot; downstream stall
//   stall_id          combinational freeze request for PC and IF/ID
//   ex_*              registered execute-stage flags and payload
//   stall_cnt         saturating count of load-use bubbles inserted
module id_ex_operand_stage #(
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              id_valid,
  input  logic [3:0]        id_rn,
  input  logic [3:0]        id_rm,
  input  logic [3:0]        id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_we,
  input  logic              id_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       rf_y1,
  input  logic [31:0]       rf_y2,
  input  logic [3:0]        ex_fw_rd,
  input  logic [3:0]        mem_fw_rd,
  input  logic [3:0]        wb_fw_rd,
  input  logic              ex_fw_we,
  input  logic              mem_fw_we,
  input  logic              wb_fw_we,
  input  logic              ex_fw_load,
  input  logic [31:0]       ex_fw_data,
  input  logic [31:0]       mem_fw_data,
  input  logic [31:0]       wb_fw_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_load,
  output logic [3:0]        ex_rd,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       stall_cnt
);

  logic        hazard;
  logic [31:0] op_a_sel;
  logic [31:0] op_b_sel;

  // Youngest producer wins. A load in EX has no data yet, so it is skipped here;
  // if the source is really used, the hazard path bubbles this cycle anyway.
  // WB must be forwarded because the register file writes on the same edge.
  function automatic logic [31:0] fwd(input logic [3:0] src, input logic [31:0] rf);
    if (ex_fw_we && !ex_fw_load && (ex_fw_rd == src)) begin
      return ex_fw_data;
    end else if (mem_fw_we && (mem_fw_rd == src)) begin
      return mem_fw_data;
    end else if (wb_fw_we && (wb_fw_rd == src)) begin
      return wb_fw_data;
    end
    return rf;
  endfunction

  always_comb begin
    op_a_sel = fwd(id_rn, rf_y1);
    op_b_sel = fwd(id_rm, rf_y2);
    hazard   = id_valid & ex_fw_load & ex_fw_we &
               ((id_use_rn & (ex_fw_rd == id_rn)) | (id_use_rm & (ex_fw_rd == id_rm)));
    stall_id = ~flush & (ex_hold | hazard);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      ex_op_a   <= '0;
      ex_op_b   <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else if (flush || (!ex_hold && hazard)) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
      ex_rd    <= '0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_ctrl  <= '0;
      // Only a load-use bubble counts; a flushed slot is not a stall.
      if (!flush && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end else if (!ex_hold) begin
      ex_valid <= id_valid;
      ex_we    <= id_we & id_valid;
      ex_load  <= id_load & id_valid;
      ex_rd    <= id_rd;
      ex_op_a  <= op_a_sel;
      ex_op_b  <= op_b_sel;
      ex_ctrl  <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        load;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        id_valid, id_use_rn, id_use_rm, id_we, id_load;
  logic [3:0]  id_rn, id_rm, id_rd;
  logic [7:0]  id_ctrl;
  logic [31:0] rf_y1, rf_y2;
  logic [3:0]  ex_fw_rd, mem_fw_rd, wb_fw_rd;
  logic        ex_fw_we, mem_fw_we, wb_fw_we, ex_fw_load;
  logic [31:0] ex_fw_data, mem_fw_data, wb_fw_data;
  logic        flush, ex_hold;
  logic        stall_id, ex_valid, ex_we, ex_load;
  logic [3:0]  ex_rd;
  logic [31:0] ex_op_a, ex_op_b;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t zero_exp;
  exp_t held;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.CTRL_W(8)) dut (
    .clk(clk), .clear(clear),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_we(id_we), .id_load(id_load),
    .id_ctrl(id_ctrl), .rf_y1(rf_y1), .rf_y2(rf_y2),
    .ex_fw_rd(ex_fw_rd), .mem_fw_rd(mem_fw_rd), .wb_fw_rd(wb_fw_rd),
    .ex_fw_we(ex_fw_we), .mem_fw_we(mem_fw_we), .wb_fw_we(wb_fw_we),
    .ex_fw_load(ex_fw_load), .ex_fw_data(ex_fw_data), .mem_fw_data(mem_fw_data),
    .wb_fw_data(wb_fw_data), .flush(flush), .ex_hold(ex_hold),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_we(ex_we), .ex_load(ex_load),
    .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  function automatic exp_t observed();
    exp_t o;
    o = '{valid: ex_valid, we: ex_we, load: ex_load, rd: ex_rd, a: ex_op_a, b: ex_op_b,
          ctrl: ex_ctrl, cnt: stall_cnt};
    return o;
  endfunction

  function automatic exp_t mk(input logic v, input logic w, input logic l, input logic [3:0] rd,
                              input logic [31:0] a, input logic [31:0] b, input logic [7:0] c,
                              input logic [15:0] n);
    exp_t e;
    e = '{valid: v, we: w, load: l, rd: rd, a: a, b: b, ctrl: c, cnt: n};
    return e;
  endfunction

  task automatic chk_state(input string tag, input exp_t e);
    exp_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_stall(input string tag, input logic e);
    checks++;
    assert (stall_id === e) else begin
      errors++;
      $error("FAIL %s stall_id: got %b expected %b", tag, stall_id, e);
    end
  endtask

  // Called just after a falling edge with inputs driven: checks stall_id, queues the
  // expected EX state, clocks once and compares against the queue head.
  task automatic cycle(input string tag, input exp_t e, input logic exp_stall);
    exp_t want;
    #1;
    chk_stall(tag, exp_stall);
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    chk_state(tag, want);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_we = 0; id_load = 0;
    id_rn = 0; id_rm = 0; id_rd = 0; id_ctrl = 0; rf_y1 = 0; rf_y2 = 0;
    ex_fw_rd = 0; mem_fw_rd = 0; wb_fw_rd = 0;
    ex_fw_we = 0; mem_fw_we = 0; wb_fw_we = 0; ex_fw_load = 0;
    ex_fw_data = 0; mem_fw_data = 0; wb_fw_data = 0;
    flush = 0; ex_hold = 0;
  endtask

  task automatic set_id(input logic v, input logic w, input logic l, input logic [3:0] rd,
                        input logic [3:0] rn, input logic [3:0] rm, input logic urn,
                        input logic urm, input logic [31:0] y1, input logic [31:0] y2,
                        input logic [7:0] c);
    id_valid = v; id_we = w; id_load = l; id_rd = rd; id_rn = rn; id_rm = rm;
    id_use_rn = urn; id_use_rm = urm; rf_y1 = y1; rf_y2 = y2; id_ctrl = c;
  endtask

  initial begin
    zero_exp = '0;
    idle();
    clear = 0;
    #3;
    chk_state("reset_state", zero_exp);
    chk_stall("reset_state", 1'b0);
    @(negedge clk);
    clear = 1;

    // Load nonzero state, then an asynchronous clear between edges.
    set_id(1, 1, 0, 4'd7, 4'd1, 4'd2, 1, 1, 32'hA1, 32'hB2, 8'h5A);
    cycle("preload", mk(1, 1, 0, 4'd7, 32'hA1, 32'hB2, 8'h5A, 16'd0), 1'b0);
    clear = 0;
    #2;
    chk_state("async_clear", zero_exp);
    clear = 1;
    cycle("after_clear", mk(1, 1, 0, 4'd7, 32'hA1, 32'hB2, 8'h5A, 16'd0), 1'b0);

    // Forwarding priority on source A.
    idle();
    set_id(1, 1, 0, 4'd9, 4'd3, 4'd4, 1, 1, 32'h44, 32'h55, 8'h01);
    ex_fw_rd = 3;  ex_fw_we = 1;  ex_fw_data = 32'h11;
    mem_fw_rd = 3; mem_fw_we = 1; mem_fw_data = 32'h22;
    wb_fw_rd = 3;  wb_fw_we = 1;  wb_fw_data = 32'h33;
    cycle("prio_ex", mk(1, 1, 0, 4'd9, 32'h11, 32'h55, 8'h01, 16'd0), 1'b0);
    ex_fw_we = 0;
    cycle("prio_mem", mk(1, 1, 0, 4'd9, 32'h22, 32'h55, 8'h01, 16'd0), 1'b0);
    mem_fw_we = 0;
    cycle("prio_wb", mk(1, 1, 0, 4'd9, 32'h33, 32'h55, 8'h01, 16'd0), 1'b0);
    wb_fw_we = 0;
    cycle("prio_rf", mk(1, 1, 0, 4'd9, 32'h44, 32'h55, 8'h01, 16'd0), 1'b0);

    // r0 and r15 forward; an unused EX-load match neither stalls nor supplies data.
    idle();
    set_id(1, 0, 1, 4'd2, 4'd0, 4'd15, 0, 1, 32'h1, 32'h2, 8'hC3);
    wb_fw_rd = 0;   wb_fw_we = 1;  wb_fw_data = 32'h100;
    mem_fw_rd = 15; mem_fw_we = 1; mem_fw_data = 32'h200;
    ex_fw_rd = 0;   ex_fw_we = 1;  ex_fw_load = 1; ex_fw_data = 32'hBAD;
    cycle("reg0_reg15", mk(1, 0, 1, 4'd2, 32'h100, 32'h200, 8'hC3, 16'd0), 1'b0);

    // Load-use on source B, then the load forwards from MEM.
    idle();
    set_id(1, 1, 0, 4'd6, 4'd1, 4'd5, 1, 1, 32'h10, 32'h20, 8'h33);
    ex_fw_rd = 5; ex_fw_we = 1; ex_fw_load = 1; ex_fw_data = 32'h999;
    cycle("load_use", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'd1), 1'b1);
    ex_fw_we = 0; ex_fw_load = 0;
    mem_fw_rd = 5; mem_fw_we = 1; mem_fw_data = 32'hDEAD;
    cycle("load_fwd_mem", mk(1, 1, 0, 4'd6, 32'h10, 32'hDEAD, 8'h33, 16'd1), 1'b0);

    // Both sources hit the load: one bubble.
    idle();
    set_id(1, 1, 0, 4'd6, 4'd5, 4'd5, 1, 1, 32'h10, 32'h20, 8'h33);
    ex_fw_rd = 5; ex_fw_we = 1; ex_fw_load = 1;
    cycle("hazard_both", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'd2), 1'b1);
    flush = 1;
    cycle("flush_hazard", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'd2), 1'b0);

    // Hold for three cycles with changing decode inputs.
    idle();
    set_id(1, 1, 1, 4'd8, 4'd1, 4'd2, 1, 1, 32'h111, 32'h222, 8'h44);
    held = mk(1, 1, 1, 4'd8, 32'h111, 32'h222, 8'h44, 16'd2);
    cycle("pre_hold", held, 1'b0);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 0, 4'(i + 11), 4'd3, 4'd4, 1, 1, 32'h900 + i, 32'hA00 + i, 8'(i));
      cycle("hold", held, 1'b1);
    end
    ex_hold = 0;
    set_id(1, 0, 0, 4'd10, 4'd1, 4'd2, 1, 1, 32'h333, 32'h444, 8'h77);
    cycle("hold_release", mk(1, 0, 0, 4'd10, 32'h333, 32'h444, 8'h77, 16'd2), 1'b0);

    // Invalid slot: flags cleared, payload still loaded, no hazard from the EX load.
    set_id(0, 1, 1, 4'd12, 4'd1, 4'd2, 1, 1, 32'h55, 32'h66, 8'h88);
    ex_fw_rd = 1; ex_fw_we = 1; ex_fw_load = 1;
    cycle("id_invalid", mk(0, 0, 0, 4'd12, 32'h55, 32'h66, 8'h88, 16'd2), 1'b0);

    // Saturation: keep a hazard asserted until the counter tops out.
    idle();
    set_id(1, 1, 0, 4'd6, 4'd5, 4'd1, 1, 0, 32'h1, 32'h2, 8'h01);
    ex_fw_rd = 5; ex_fw_we = 1; ex_fw_load = 1;
    repeat (65532) @(posedge clk);
    @(negedge clk);
    chk_state("sat_fffe", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'hFFFE));
    cycle("sat_ffff", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'hFFFF), 1'b1);
    cycle("sat_hold1", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'hFFFF), 1'b1);
    cycle("sat_hold2", mk(0, 0, 0, 4'd0, 32'h0, 32'h0, 8'h00, 16'hFFFF), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

Interface
REQ-001 Parameter CTRL_W, default 8, width of the opaque control bundle carried from decode to execute.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_rn, id_rm, id_rd  input  4 each  source A, source B, destination register numbers.
REQ-006 id_use_rn, id_use_rm  input  1 each  instruction actually reads that source.
REQ-007 id_we, id_load  input  1 each  instruction writes id_rd; instruction is a load.
REQ-008 id_ctrl  input  CTRL_W  decode control bundle, passed through untouched.
REQ-009 rf_y1, rf_y2  input  32 each  register-file read data for id_rn, id_rm.
REQ-010 ex_fw_rd, mem_fw_rd, wb_fw_rd  input  4 each  destination of instruction currently in EX, MEM, WB.
REQ-011 ex_fw_we, mem_fw_we, wb_fw_we  input  1 each  that stage will write its destination.
REQ-012 ex_fw_load  input  1  instruction in EX is a load.
REQ-013 ex_fw_data, mem_fw_data, wb_fw_data  input  32 each  result value available in that stage (mem_fw_data includes load data).
REQ-014 flush, ex_hold  input  1 each  kill decode slot (taken branch); downstream stall.
REQ-015 stall_id  output  1  combinational; freeze PC and IF/ID latch this cycle.
REQ-016 ex_valid, ex_we, ex_load  output  1 each  registered execute-stage flags.
REQ-017 ex_rd  output  4; ex_op_a, ex_op_b  output  32 each; ex_ctrl  output  CTRL_W  registered execute-stage payload.
REQ-018 stall_cnt  output  16  saturating count of load-use bubbles inserted.

Function
REQ-019 Operand select (per source, combinational): EX match beats MEM match beats WB match beats rf value; match = stage we=1 and stage rd equals source number.
REQ-020 EX match with ex_fw_load=1 supplies no data; it raises load-use hazard instead.
REQ-021 Load-use hazard = id_valid & ex_fw_load & ex_fw_we & ((id_use_rn & ex_fw_rd==id_rn) | (id_use_rm & ex_fw_rd==id_rm)).
REQ-022 WB forwarding is mandatory: register file writes on the same edge, so rf data is stale in that cycle.
REQ-023 stall_id = ~flush & (ex_hold | hazard).
REQ-024 Edge update priority: flush > ex_hold > hazard > normal.
REQ-025 flush=1: EX latch loads bubble (ex_valid=0, ex_we=0, ex_load=0, ex_rd=0, ex_op_a=ex_op_b=0, ex_ctrl=0); no stall.
REQ-026 ex_hold=1 (no flush): all EX outputs hold previous values.
REQ-027 hazard=1 (no flush, no hold): EX latch loads bubble; stall_cnt increments unless at 16'hFFFF (saturates, no wrap).
REQ-028 Normal: EX latch loads id_valid, id_we&id_valid, id_load&id_valid, id_rd, selected operands, id_ctrl; latency one cycle.
REQ-029 id_valid=0 in normal case: ex_valid=ex_we=ex_load=0; payload fields still loaded.
REQ-030 Hazard on both sources counts one bubble; a hazard lasts exactly one cycle given ex_hold=0 (load moves to MEM and forwards).
REQ-031 All register numbers 0-15 forwardable; no register is special-cased.

Reset
REQ-032 clear=0 immediately (no clock) forces every EX output and stall_cnt to 0; stall_id then follows REQ-023 combinationally.
REQ-033 clear deassertion mid-operation: first rising edge after release performs a normal update.

Verification
REQ-034 Reset: drive ex outputs nonzero, pulse clear=0 between edges -> all registered outputs 0 before next edge.
REQ-035 Priority: rn=3, EX rd=3 data 0x11, MEM rd=3 data 0x22, WB rd=3 data 0x33, rf_y1=0x44 -> ex_op_a=0x11; drop EX we -> 0x22; drop MEM we -> 0x33; drop WB we -> 0x44.
REQ-036 Load-use: EX load rd=5, ID uses rm=5 -> stall_id=1, next ex_valid=0, stall_cnt=1; following cycle MEM rd=5 data 0xDEAD -> ex_op_b=0xDEAD, ex_valid=1.
REQ-037 Flush vs hazard: same as REQ-036 plus flush=1 -> stall_id=0, bubble, stall_cnt unchanged.
REQ-038 Hold: ex_hold=1 for 3 cycles with changing ID inputs -> EX outputs constant, stall_id=1; release -> new values in one cycle.
REQ-039 Saturation: preload 0xFFFE via 2 extra hazards after 0xFFFC... -> reaches 0xFFFF and stays 0xFFFF on further hazards.
